// File: rtl/cgra_clkgate_ctrl.sv
// cgra_clkgate_ctrl: per-channel enable controller for CGRA clock-gate cells.
// Wake with settle delay, activity hold, idle hysteresis, then gate off.
module cgra_clkgate_ctrl #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             force_en_i,
  input  logic [N_CH-1:0]  req_i,
  input  logic [N_CH-1:0]  busy_i,
  input  logic [CNT_W-1:0] idle_thr_i,
  output logic [N_CH-1:0]  en_o,
  output logic [N_CH-1:0]  ack_o,
  output logic [N_CH-1:0]  gated_o
);

  // Counter must hold both the hysteresis threshold and the wake delay.
  localparam int WW = $clog2(WAKE_CYC + 1);
  localparam int CW = (CNT_W > WW) ? CNT_W : WW;

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_COOL
  } state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch

    state_t          st_q;
    state_t          st_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            act;
    logic            en_q;
    logic            ack_q;
    logic            gated_q;

    assign act = req_i[c] | busy_i[c];

    // Next-state and counter update for this channel.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        S_OFF: begin
          if (act) begin
            st_d  = S_WAKE;
            cnt_d = WAKE_LD;
          end
        end
        S_WAKE: begin
          if (cnt_q == ONE) begin
            st_d  = S_ON;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_ON: begin
          if (!act) begin
            if (idle_thr_i == '0) begin
              st_d  = S_OFF;
              cnt_d = '0;
            end else begin
              st_d  = S_COOL;
              cnt_d = CW'(idle_thr_i);
            end
          end
        end
        S_COOL: begin
          if (act) begin
            st_d  = S_ON;
            cnt_d = '0;
          end else if (cnt_q == ONE) begin
            st_d  = S_OFF;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: begin
          st_d  = S_OFF;
          cnt_d = '0;
        end
      endcase
    end

    // State, counter and outputs registered from next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        st_q    <= S_OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        ack_q   <= 1'b0;
        gated_q <= 1'b1;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        en_q    <= (st_d != S_OFF) | force_en_i;
        ack_q   <= (st_d == S_ON) | (st_d == S_COOL);
        gated_q <= (st_d == S_OFF);
      end
    end

    assign en_o[c]    = en_q;
    assign ack_o[c]   = ack_q;
    assign gated_o[c] = gated_q;

  end

endmodule

// File: tb/tb_cgra_clkgate_ctrl.sv
// tb_cgra_clkgate_ctrl: directed vectors with a tagged expectation queue.
// A negedge monitor compares DUT outputs against entries due at that edge.
module tb_cgra_clkgate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       force_en = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] busy = '0;
  logic [7:0] thr = '0;
  logic [3:0] en;
  logic [3:0] ack;
  logic [3:0] gated;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int         tag;
    logic [3:0] en;
    logic [3:0] ack;
    logic [3:0] gated;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  cgra_clkgate_ctrl #(
    .N_CH(4),
    .CNT_W(8),
    .WAKE_CYC(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .force_en_i(force_en),
    .req_i(req),
    .busy_i(busy),
    .idle_thr_i(thr),
    .en_o(en),
    .ack_o(ack),
    .gated_o(gated)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input int tag,
                     input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b want=%b", nm, tag, a, e);
    end
  endtask

  // Monitor: pop every expectation due at the edge just passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= edge_cnt) begin
      mon_e = q.pop_front();
      if (mon_e.tag != edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL missed edge=%0d now=%0d", mon_e.tag, edge_cnt);
      end else begin
        chk("en", mon_e.tag, en, mon_e.en);
        chk("ack", mon_e.tag, ack, mon_e.ack);
        chk("gated", mon_e.tag, gated, mon_e.gated);
      end
    end
  end

  // Apply inputs before the next edge and expect outputs after it.
  task automatic step(input logic f, input logic [3:0] r,
                      input logic [3:0] b, input logic [7:0] t,
                      input logic [3:0] e, input logic [3:0] a,
                      input logic [3:0] g);
    @(negedge clk);
    force_en = f;
    req = r;
    busy = b;
    thr = t;
    q.push_back('{tag: edge_cnt + 1, en: e, ack: a, gated: g});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    q.push_back('{tag: edge_cnt + 1, en: 4'b0000,
                  ack: 4'b0000, gated: 4'b1111});
    @(negedge clk);
    #1 rst = 1'b0;

    // ch0 wake: en after E0, ack after E2
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0001, 4'b0000, 4'b1110);
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0001, 4'b0000, 4'b1110);
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0001, 4'b0001, 4'b1110);

    // ch1 wake, then 3-cycle cooldown; thr change mid-COOL ignored
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0001, 4'b1100);
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0001, 4'b1100);
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd10, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd10, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd10, 4'b0001, 4'b0001, 4'b1110);

    // ch1 again: busy pulse in 2nd COOL cycle, then thr=0 direct off
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0001, 4'b1100);
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0001, 4'b1100);
    step(0, 4'b0011, 4'b0000, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0010, 8'd3, 4'b0011, 4'b0011, 4'b1100);
    step(0, 4'b0001, 4'b0000, 8'd0, 4'b0001, 4'b0001, 4'b1110);

    // ch2 one-cycle pulse: full wake, one ON cycle, 2-cycle COOL
    step(0, 4'b0101, 4'b0000, 8'd2, 4'b0101, 4'b0001, 4'b1010);
    step(0, 4'b0001, 4'b0000, 8'd2, 4'b0101, 4'b0001, 4'b1010);
    step(0, 4'b0001, 4'b0000, 8'd2, 4'b0101, 4'b0101, 4'b1010);
    step(0, 4'b0001, 4'b0000, 8'd2, 4'b0101, 4'b0101, 4'b1010);
    step(0, 4'b0001, 4'b0000, 8'd2, 4'b0101, 4'b0101, 4'b1010);
    step(0, 4'b0001, 4'b0000, 8'd2, 4'b0001, 4'b0001, 4'b1110);

    // all off, then force override
    step(0, 4'b0000, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b1111);
    step(1, 4'b0000, 4'b0000, 8'd0, 4'b1111, 4'b0000, 4'b1111);
    step(0, 4'b0000, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b1111);

    // ch3 into WAKE, then asynchronous reset mid-cycle
    step(0, 4'b1000, 4'b0000, 8'd0, 4'b1000, 4'b0000, 4'b0111);
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("rst_en", edge_cnt, en, 4'b0000);
    chk("rst_ack", edge_cnt, ack, 4'b0000);
    chk("rst_gated", edge_cnt, gated, 4'b1111);
    @(negedge clk);
    rst = 1'b0;

    // counter reloads cleanly after reset
    step(0, 4'b0000, 4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b1111);
    step(0, 4'b1000, 4'b0000, 8'd0, 4'b1000, 4'b0000, 4'b0111);
    step(0, 4'b1000, 4'b0000, 8'd0, 4'b1000, 4'b0000, 4'b0111);
    step(0, 4'b1000, 4'b0000, 8'd0, 4'b1000, 4'b1000, 4'b0111);

    repeat (2) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover pending=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
